// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that holds the PC, issues word fetches to imem and hands instructions to decode
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   imem_req, imem_addr             fetch request and word-aligned byte address (addr is pc_r at all times)
//   imem_ready                      imem accepts the request this cycle
//   imem_rvalid, imem_rdata         returned instruction word
//   redirect_en, redirect_pc        taken branch/jump from execute; discards any fetch in flight
//   out_valid, out_ready            valid/ready handshake to decode
//   instr, pc, pc_plus4             fetched instruction, its address and address + 4
//   misalign_err                    sticky misaligned-redirect flag (MISALIGN_TRAP_EN builds only, else 0)
//
// Build option: define MISALIGN_TRAP_EN to halt on a misaligned redirect target instead of masking it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);
`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;
`endif
  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] target;
  assign target    = redirect_pc & ~32'h3;
  assign imem_req  = state == REQ;
  assign out_valid = state == HOLD;
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign pc_plus4  = pc_r + 32'd4;
`ifdef MISALIGN_TRAP_EN
  logic trap;
  logic err_r;
  assign trap         = redirect_en && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = err_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_r <= 1'b0;
    else if (trap && state != IDLE && state != HALT) err_r <= 1'b1;
`else
  assign misalign_err = 1'b0;
`endif
  // DROP means one accepted request is still owed by imem and its data must be thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_r  <= RESET_PC;
      instr <= 32'h0000_0013;
    end else begin
`ifdef MISALIGN_TRAP_EN
      // HALT never leaves and ignores rvalid, so any owed response is implicitly discarded.
      if (trap && state != IDLE && state != HALT) state <= HALT;
      else
`endif
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (redirect_en) begin
            pc_r  <= target;
            state <= imem_ready ? DROP : REQ;
          end else if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (redirect_en) begin
            pc_r  <= target;
            state <= imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= HOLD;
          end
        end
        DROP: begin
          if (redirect_en) pc_r <= target;
          if (imem_rvalid) state <= REQ;
        end
        HOLD: begin
          if (redirect_en) begin
            pc_r  <= target;
            state <= REQ;
          end else if (out_ready) begin
            pc_r  <= pc_r + 32'd4;
            state <= REQ;
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of decode and the immediate sign-extend unit.
- Holds the PC and issues word fetches to instruction memory over a req/ready plus rvalid handshake.
- Presents the fetched instruction with its pc and pc_plus4 to decode over a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage and discards any fetch in flight when one arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (byte address, word aligned)
imem_ready  input  1  imem accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  fetched instruction word
redirect_en  input  1  branch/jump taken
redirect_pc  input  32  redirect target
out_valid  output  1  instr/pc/pc_plus4 valid to decode
out_ready  input  1  decode accepts
instr  output  32  fetched instruction
pc  output  32  address of instr
pc_plus4  output  32  pc + 4
misalign_err  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, pc_r=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - out_valid=0, instr=32'h0000_0013 (NOP), pc=RESET_PC, pc_plus4=RESET_PC+4.
  - misalign_err=0.
- Reset mid-operation: the outstanding request is abandoned. Imem must not return rvalid for it after reset release.
- Output decode:
  - imem_req=1 only in REQ; imem_addr=pc_r at all times.
  - pc=pc_r; pc_plus4=pc_r+32'd4, 32-bit wrap (FFFF_FFFC -> 0000_0000).
  - out_valid=1 only in HOLD. instr is registered and is stable while out_valid=1.
- At most one outstanding imem request.
- FSM, checked in priority order within each state:
  - IDLE: go to REQ next cycle.
  - REQ:
    - redirect_en && imem_ready: old request accepted; pc_r<=target; go to DROP.
    - redirect_en only: pc_r<=target; stay in REQ, new address driven next cycle.
    - imem_ready only: go to WAIT.
  - WAIT:
    - redirect_en && imem_rvalid: discard data; pc_r<=target; go to REQ.
    - redirect_en only: pc_r<=target; go to DROP.
    - imem_rvalid only: instr<=imem_rdata; go to HOLD.
  - DROP:
    - redirect_en: pc_r<=target; stay in DROP; still owes one discard.
    - imem_rvalid: discard data; go to REQ. If redirect_en and imem_rvalid coincide: pc_r<=target; go to REQ.
  - HOLD:
    - redirect_en: flush; out_valid drops next cycle; pc_r<=target; go to REQ. Redirect wins over out_ready.
    - out_ready: pc_r<=pc_r+4; go to REQ.
    - neither: hold all outputs stable.
- Latency and throughput:
  - Zero-wait imem (ready in REQ, rvalid the following cycle): REQ->WAIT->HOLD.
  - First out_valid appears 3 cycles after reset release.
  - Steady throughput is 1 instruction per 3 cycles with out_ready held high.
- imem_rvalid in IDLE/REQ/HOLD is a protocol error and is ignored.
- Target handling: target = redirect_pc with bits[1:0] forced to 0, unless the Optional Feature is compiled in.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 is not applied.
  - misalign_err<=1, sticky until reset.
  - FSM enters HALT: imem_req=0, out_valid=0, redirect_en ignored.
  - If the trap occurs in WAIT/DROP, a subsequent rvalid is discarded.
- Undefined:
  - Low bits are masked as above.
  - misalign_err is tied 0.
  - The HALT state does not exist.

Test Plan:
- Reset release, zero-wait imem returning 32'h0000_0093 at 0x0, out_ready=1 -> out_valid high on cycle 3 with pc=0x0, instr=0x0000_0093, pc_plus4=0x4; next fetch at imem_addr=0x4.
- out_ready=0 for 5 cycles in HOLD -> instr/pc stable, imem_req=0 throughout; on out_ready=1, the next request is issued at pc+4.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEAD_BEEF -> data discarded, out_valid never asserted for it, next imem_addr=0x100.
- Redirect to 0x200 in the same cycle as imem_ready in REQ (addr 0x8) -> DROP; first rvalid discarded; next request at 0x200.
- Redirect to 0x40 and out_ready both high in HOLD -> out_valid=0 next cycle, next request at 0x40, not pc+4.
- pc=0xFFFF_FFFC -> pc_plus4=0x0. With MISALIGN_TRAP_EN, redirect_pc=0x102 -> misalign_err=1, imem_req stays 0 until rst_n low. Without it, the next fetch is at 0x100.
